// File: rtl/uart_tx_ctrl_pkg.sv
// uart_tx_ctrl_pkg
//   Shared constants for the UART transmit frame sequencer.
//   - SEL_* : encodings of the 2-bit select of the registered TX output mux
//   - state_e : frame sequencer FSM states
//   - PAR_* : parity-type encodings for PAR_TYP
package uart_tx_ctrl_pkg;

  localparam int SEL_WIDTH = 2;

  // TX output mux select values
  localparam logic [SEL_WIDTH-1:0] SEL_START = 2'b00;  // line driven 0
  localparam logic [SEL_WIDTH-1:0] SEL_STOP  = 2'b01;  // line driven 1 (stop / idle)
  localparam logic [SEL_WIDTH-1:0] SEL_DATA  = 2'b10;  // line driven by ser_data
  localparam logic [SEL_WIDTH-1:0] SEL_PAR   = 2'b11;  // line driven by par_bit

  // Frame sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // Parity type encodings
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if
//   Word handshake between the register file / async FIFO read side and the
//   UART transmit frame sequencer.
//   P_DATA     : parallel word, sampled on an accepted handshake
//   DATA_VALID : request to send P_DATA
//   PAR_EN     : include a parity bit in the frame (sampled with P_DATA)
//   PAR_TYP    : 0 = even, 1 = odd (sampled with P_DATA)
//   DATA_READY : sequencer can accept a word this cycle
//   master drives the word, slave (the sequencer) drives DATA_READY.
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  DATA_READY;

  modport master (
    output P_DATA,
    output DATA_VALID,
    output PAR_EN,
    output PAR_TYP,
    input  DATA_READY
  );

  modport slave (
    input  P_DATA,
    input  DATA_VALID,
    input  PAR_EN,
    input  PAR_TYP,
    output DATA_READY
  );
endinterface

// File: rtl/uart_tx_ctrl_parity_calc.sv
// uart_tx_parity_calc
//   Combinational parity generator for one transmit word.
//   data_i     : word to protect
//   par_typ_i  : PAR_EVEN / PAR_ODD
//   par_bit_o  : bit that makes the total count of ones even (PAR_EVEN)
//                or odd (PAR_ODD) across data and parity
module uart_tx_parity_calc
  import uart_tx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  par_bit_o
);

  assign par_bit_o = (^data_i) ^ (par_typ_i == PAR_ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
//   UART transmit frame sequencer. Accepts one word per handshake, then walks
//   start bit, DATA_WIDTH data bits (LSB first), optional parity bit and stop
//   bit, one bit per CLK, by steering the select of the registered TX mux.
//   CLK      : TX bit clock
//   RST      : asynchronous, active-low reset
//   bus      : word handshake (slave side), DATA_READY driven here
//   mux_sel  : TX mux select (SEL_START / SEL_STOP / SEL_DATA / SEL_PAR)
//   ser_data : current data bit, valid while mux_sel = SEL_DATA
//   par_bit  : parity of the latched word (registered)
//   busy     : frame in progress (registered)
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_tx_ctrl_if.slave        bus,
  output logic [SEL_WIDTH-1:0] mux_sel,
  output logic                 ser_data,
  output logic                 par_bit,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  busy_q, busy_d;

  logic                  ready;
  logic                  accept;
  logic                  par_calc;

  uart_tx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data_i    (bus.P_DATA),
    .par_typ_i (bus.PAR_TYP),
    .par_bit_o (par_calc)
  );

  // A new word may be taken while idle or during the stop bit, which lets
  // back-to-back frames run without an idle gap.
  assign ready  = (state_q == IDLE) || (state_q == STOP);
  assign accept = bus.DATA_VALID && ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    busy_d    = busy_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d   = bus.P_DATA;
          par_en_d  = bus.PAR_EN;
          par_bit_d = par_calc;
          busy_d    = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        shreg_d = shreg_q >> 1;
        if (cnt_q == CNT_LAST) begin
          // Leave the counter at zero rather than letting it wrap
          cnt_d   = '0;
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        state_d = STOP;
      end
      STOP: begin
        if (accept) begin
          shreg_d   = bus.P_DATA;
          par_en_d  = bus.PAR_EN;
          par_bit_d = par_calc;
          busy_d    = 1'b1;
          state_d   = START;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      busy_q    <= busy_d;
    end
  end

  // Moore decode of the mux select from the registered state
  always_comb begin
    mux_sel = SEL_STOP;
    case (state_q)
      START:   mux_sel = SEL_START;
      DATA:    mux_sel = SEL_DATA;
      PARITY:  mux_sel = SEL_PAR;
      default: mux_sel = SEL_STOP;
    endcase
  end

  assign ser_data       = (state_q == DATA) && shreg_q[0];
  assign par_bit        = par_bit_q;
  assign busy           = busy_q;
  assign bus.DATA_READY = ready;

endmodule
